// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into short, long and double presses (one-cycle pulses).
// Define BPC_AUTO_REPEAT_EN to get repeat_press pulses while a long press is held.
module button_press_classifier #(
  parameter int CW            = 27,
  parameter int LONG_CYCLES   = 100000000,
  parameter int DBL_CYCLES    = 30000000,
  parameter int REPEAT_CYCLES = 20000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic db_level,
  input  logic db_tick,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic repeat_press,
  output logic busy
);

  // state     | meaning
  // IDLE      | waiting for a press
  // PRESS1    | first press held, timing toward long
  // GAP       | released, waiting for a second press or timeout
  // PRESS2    | second press held, double on release
  // LONG_HELD | long press reported, waiting for release
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PRESS1    = 3'd1;
  localparam logic [2:0] GAP       = 3'd2;
  localparam logic [2:0] PRESS2    = 3'd3;
  localparam logic [2:0] LONG_HELD = 3'd4;

  localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] DBL_TC  = CW'(DBL_CYCLES - 1);

  localparam longint CNT_RANGE = 64'd1 << CW;

  if (LONG_CYCLES < 2 || DBL_CYCLES < 2 ||
      longint'(LONG_CYCLES) >= CNT_RANGE || longint'(DBL_CYCLES) >= CNT_RANGE ||
      longint'(REPEAT_CYCLES) >= CNT_RANGE) begin : g_param_check
    $error("button_press_classifier: parameter out of range for CW");
  end

  logic [2:0]    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          lvl_q;
  logic          rel;
  logic          short_next, long_next, double_next;

  // Release is taken from the registered level so a tick/level skew can't fake one
  assign rel = lvl_q & ~db_level;

`ifdef BPC_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);
  logic repeat_next;
`endif

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;
`ifdef BPC_AUTO_REPEAT_EN
    repeat_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (db_tick) begin
          state_next = PRESS1;
          cnt_next   = '0;
        end
      end
      PRESS1: begin
        if (rel) begin
          state_next = GAP;
          cnt_next   = '0;
        end else if (cnt == LONG_TC) begin
          state_next = LONG_HELD;
          cnt_next   = '0;
          long_next  = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      GAP: begin
        if (db_tick) begin
          state_next = PRESS2;
          cnt_next   = '0;
        end else if (cnt == DBL_TC) begin
          state_next = IDLE;
          cnt_next   = '0;
          short_next = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      PRESS2: begin
        if (rel) begin
          state_next  = IDLE;
          cnt_next    = '0;
          double_next = 1'b1;
        end
      end
      LONG_HELD: begin
        if (rel) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
`ifdef BPC_AUTO_REPEAT_EN
        else if (cnt == REPEAT_TC) begin
          cnt_next    = '0;
          repeat_next = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
`endif
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      lvl_q        <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      lvl_q        <= db_level;
      short_press  <= short_next;
      long_press   <= long_next;
      double_press <= double_next;
      busy         <= (state_next != IDLE);
    end
  end

`ifdef BPC_AUTO_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) repeat_press <= 1'b0;
    else        repeat_press <= repeat_next;
  end
`else
  assign repeat_press = 1'b0;
`endif

endmodule
